// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] EXTEND_CODE = 8'hE0;
    localparam int         DATA_BITS   = 8;

endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through byte FIFO; head is valid in the cycle after the write edge.
// A write while full is dropped unless a pop happens on the same edge; drops set a sticky overflow.
module ps2_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_i,
    input  logic [7:0] wr_dat_i,
    input  logic       rd_i,
    output logic [7:0] rd_dat_o,
    output logic       empty_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        ovf_q;
    logic        full;
    logic        empty;
    logic        do_rd;
    logic        do_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd = rd_i && !empty;
    assign do_wr = wr_i && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_i && !do_wr) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

    assign rd_dat_o   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o    = empty;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_scan_capture.sv
// PS/2 keyboard receiver: buffers scan bytes in a FIFO and tracks the held key.
// Optional mid-frame watchdog is built when PS2_TIMEOUT_EN is defined.
module ps2_scan_capture
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3
`ifdef PS2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] fifo_data,
    output logic       fifo_ready,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_valid
);

    localparam int CW = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   fall;

    ps2_state_e             state_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   wr_q;
    logic [7:0]             byte_q;
    logic                   err_q;
    logic                   timeout;

    logic [7:0]             key_code_q, key_code_d;
    logic                   key_valid_q, key_valid_d;
    logic                   brk_q, brk_d;
    logic                   ext_q, ext_d;
    logic                   fifo_empty;
    logic                   unused_ext;

    // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q && !ps2_clk_s;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;

    assign timeout = (state_q != IDLE) && !fall &&
                     (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!clrn || state_q == IDLE || fall || timeout) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wr_q      <= 1'b0;
            byte_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            if (timeout) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!ps2_dat_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {ps2_dat_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                            state_q <= PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    PARITY: begin
                        par_q   <= ps2_dat_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        // Odd parity over data plus parity bit, and a high stop bit.
                        if (ps2_dat_s && (^{shift_q, par_q})) begin
                            wr_q   <= 1'b1;
                            byte_q <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        if (wr_q) begin
            if (byte_q == EXTEND_CODE) begin
                ext_d = 1'b1;
            end else if (byte_q == BREAK_CODE) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                if (byte_q == key_code_q) key_valid_d = 1'b0;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                key_code_d  = byte_q;
                key_valid_d = 1'b1;
                ext_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    // Extended keys are tracked but no output distinguishes them yet.
    assign unused_ext = ext_q;

    ps2_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .clrn       (clrn),
        .wr_i       (wr_q),
        .wr_dat_i   (byte_q),
        .rd_i       (rd_en),
        .rd_dat_o   (fifo_data),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign fifo_ready = !fifo_empty;
    assign frame_err  = err_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;

endmodule

// File: tb/tb_ps2_scan_capture.sv
// Bench for ps2_scan_capture: table vectors, hand corner sequences and a randomized model check.
`timescale 1ns/1ps
module tb_ps2_scan_capture;

    localparam int DEPTH = 8;
    localparam int HALF  = 10;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_ready;
    logic       overflow;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_valid;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_err) err_cycles++;

`ifdef PS2_TIMEOUT_EN
    ps2_scan_capture #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .fifo_data(fifo_data), .fifo_ready(fifo_ready), .overflow(overflow),
        .frame_err(frame_err), .key_code(key_code), .key_valid(key_valid));
`else
    ps2_scan_capture #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .fifo_data(fifo_data), .fifo_ready(fifo_ready), .overflow(overflow),
        .frame_err(frame_err), .key_code(key_code), .key_valid(key_valid));
`endif

    // Reference model: byte queue plus held-key rules.
    logic [7:0] m_q[$];
    bit         m_ovf;
    logic [7:0] m_key;
    bit         m_valid;
    bit         m_brk;

    function automatic void model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_key   = 8'h00;
        m_valid = 1'b0;
        m_brk   = 1'b0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovf = 1'b1;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0) begin
            if (m_brk) begin
                if (b == m_key) m_valid = 1'b0;
                m_brk = 1'b0;
            end else begin
                m_key   = b;
                m_valid = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; rd_en = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        model_reset();
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_key_code"}, key_code, m_key);
        chk({tag, "_key_valid"}, key_valid, m_valid);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_ready"}, fifo_ready, m_q.size() > 0);
        chk({tag, "_head"}, fifo_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    endtask

    task automatic pop_check(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, fifo_ready, m_q.size() > 0);
        chk({tag, "_data"}, fifo_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    typedef struct {
        logic [7:0] dat;
        bit         bad_par;
        bit         bad_stop;
        bit         pop;
        logic [7:0] exp_head;
        bit         exp_ready;
        logic [7:0] exp_key;
        bit         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] pool[6];

    initial begin
        int  e0;
        int  lat;
        bit  seen;

        vecs[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 1, 8'h1C, 1, 0};
        vecs[1]  = '{8'hF0, 0, 0, 1, 8'hF0, 1, 8'h1C, 1, 0};
        vecs[2]  = '{8'h1C, 0, 0, 1, 8'h1C, 1, 8'h1C, 0, 0};
        vecs[3]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 8'h1C, 0, 1};
        vecs[4]  = '{8'h5A, 0, 1, 0, 8'h00, 0, 8'h1C, 0, 1};
        vecs[5]  = '{8'hE0, 0, 0, 1, 8'hE0, 1, 8'h1C, 0, 0};
        vecs[6]  = '{8'h75, 0, 0, 1, 8'h75, 1, 8'h75, 1, 0};
        vecs[7]  = '{8'h75, 0, 0, 1, 8'h75, 1, 8'h75, 1, 0};
        vecs[8]  = '{8'hF0, 0, 0, 1, 8'hF0, 1, 8'h75, 1, 0};
        vecs[9]  = '{8'h33, 0, 0, 1, 8'h33, 1, 8'h75, 1, 0};
        vecs[10] = '{8'hF0, 0, 0, 1, 8'hF0, 1, 8'h75, 1, 0};
        vecs[11] = '{8'h75, 0, 0, 1, 8'h75, 1, 8'h75, 0, 0};
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h21, 8'h1C};

        do_reset();
        @(negedge clk);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_fifo_ready", fifo_ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_valid", key_valid, 0);

        for (int i = 0; i < 12; i++) begin
            e0 = err_cycles;
            send_frame(vecs[i].dat, vecs[i].bad_par, vecs[i].bad_stop);
            @(negedge clk);
            chk($sformatf("vec%0d_err", i), err_cycles - e0, vecs[i].exp_err);
            chk($sformatf("vec%0d_ready", i), fifo_ready, vecs[i].exp_ready);
            chk($sformatf("vec%0d_head", i), fifo_data, vecs[i].exp_head);
            chk($sformatf("vec%0d_key", i), key_code, vecs[i].exp_key);
            chk($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
            if (vecs[i].pop) begin
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                chk($sformatf("vec%0d_empty_after_pop", i), fifo_ready, 0);
            end
        end

        // Fill past capacity, then drain.
        do_reset();
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b0, 1'b0);
            @(negedge clk);
            if (b == 8) chk("ovf_before_full_drop", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_key_code", key_code, 8'h09);
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk);
            chk($sformatf("ovf_pop%0d", b), fifo_data, b);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        chk("ovf_drained", fifo_ready, 0);
        chk("ovf_sticky", overflow, 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_empty_ready", fifo_ready, 0);
        chk("rd_empty_data", fifo_data, 0);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared_by_reset", overflow, 0);

        // Reset in the middle of a frame discards it.
        e0 = err_cycles;
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5);
        @(negedge clk); clrn = 1'b0;
        @(negedge clk); clrn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h2B, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_err", err_cycles - e0, 0);
        chk("midrst_head", fifo_data, 8'h2B);
        chk("midrst_key", key_code, 8'h2B);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("midrst_only_one", fifo_ready, 0);

        // Read held across the write into an empty FIFO: read ignored, byte kept.
        rd_en = 1'b1;
        seen = 1'b0;
        fork
            send_frame(8'h4D, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (fifo_ready) begin
                        rd_en = 1'b0;
                        seen = 1'b1;
                        break;
                    end
                end
            end
        join
        rd_en = 1'b0;
        @(negedge clk);
        chk("wr_rd_empty_seen", seen, 1);
        chk("wr_rd_empty_head", fifo_data, 8'h4D);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;

`ifdef PS2_TIMEOUT_EN
        do_reset();
        e0 = err_cycles;
        send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 3);
        lat = HALF;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            lat++;
            if (frame_err) break;
        end
        chk("timeout_latency_ok", (lat >= 100 && lat <= 108), 1);
        repeat (4) @(negedge clk);
        chk("timeout_one_pulse", err_cycles - e0, 1);
        send_frame(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        chk("timeout_next_head", fifo_data, 8'h1C);
        chk("timeout_next_key", key_code, 8'h1C);
        chk("timeout_next_err", err_cycles - e0, 1);
`endif

        // Randomized frames against the model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit         bp;
            b  = pool[$urandom_range(0, 5)];
            bp = ($urandom_range(0, 9) == 0);
            e0 = err_cycles;
            send_frame(b, bp, 1'b0);
            if (!bp) model_accept(b);
            check_state("rnd");
            chk("rnd_err", err_cycles - e0, int'(bp));
            if ($urandom_range(0, 9) < 3) pop_check("rnd_pop");
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_q.size() > 0) pop_check("drain");
        end
        @(negedge clk);
        chk("drain_empty", fifo_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
